// File: rtl/mul_pkg.sv
// mul_pkg: shared state type and timing constants for the multiplier issue stage
package mul_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, START, WAIT} mul_issue_state_e;
  localparam int MUL_WDOG_SLACK = 2;
  function automatic int mul_cycles(input int width, input int subdiv_size);
    return (width / subdiv_size) * (width / subdiv_size);
  endfunction
endpackage

// File: rtl/mul_issue_fifo.sv
// mul_issue_fifo: DEPTH x DW show-ahead FIFO with count, full, empty and simultaneous push/pop
// Ports: push/din write side, pop/dout read side (dout is the head), count/full/empty registered status.
module mul_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int DW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop & ~empty;
  // a pop frees the slot a simultaneous push needs, even when full
  assign do_push = push & (~full | do_pop);
  // DEPTH is a power of two, so the count MSB alone marks full
  assign full = count[AW];
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: buffers operand pairs, clears/starts the sequential multiplier core and captures each product
// Ports: in_valid/in_ready/in_a/in_b operand stream; out_valid/out_ready/out_product result stream;
//        mul_a/mul_b/mul_start/mul_rst_n drive the core, mul_product/mul_done come back; err_timeout sticky watchdog.
// Optional: define MUL_ISSUE_TAG_EN to add in_tag/out_tag, carried alongside each op.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SUBDIV_SIZE = 4,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
`ifdef MUL_ISSUE_TAG_EN
  input  logic [TAG_W-1:0]   in_tag,
  output logic [TAG_W-1:0]   out_tag,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_start,
  output logic               mul_rst_n,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               mul_done,
  output logic               err_timeout
);
  localparam int N = mul_cycles(WIDTH, SUBDIV_SIZE);
  localparam int WD_LIM = N + MUL_WDOG_SLACK;
  localparam int CW = $clog2(WD_LIM + 1);
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef MUL_ISSUE_TAG_EN
  localparam int DW = 2*WIDTH + TAG_W;
  logic [TAG_W-1:0] op_tag;
`else
  localparam int DW = 2*WIDTH;
`endif
  if (WIDTH % SUBDIV_SIZE != 0 || TAG_W < 1 || DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0) begin : g_bad_params
    $error("mul_issue_ctrl: illegal parameter combination");
  end
  logic [DW-1:0] fifo_din, fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic fifo_full, fifo_empty, pop, load, timeout;
  logic [CW-1:0] wd_cnt;
  mul_issue_state_e state, state_nx;
`ifdef MUL_ISSUE_TAG_EN
  assign fifo_din = {in_tag, in_a, in_b};
`else
  assign fifo_din = {in_a, in_b};
`endif
  assign in_ready = ~fifo_full;
  mul_issue_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_valid & in_ready),
    .pop(pop),
    .din(fifo_din),
    .dout(fifo_dout),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  assert property (@(posedge clk) disable iff (rst) fifo_count <= CNT_W'(DEPTH) && !(fifo_full && fifo_empty));
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    load = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: begin
        pop = ~fifo_empty;
        state_nx = fifo_empty ? IDLE : CLEAR;
      end
      CLEAR: state_nx = START;
      START: state_nx = WAIT;
      WAIT: begin
        // a full, undrained output register stalls here; the core holds done/product meanwhile
        load = mul_done & (~out_valid | out_ready);
        timeout = ~mul_done & (wd_cnt == CW'(WD_LIM - 1));
        state_nx = (load | timeout) ? IDLE : WAIT;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      mul_a <= '0;
      mul_b <= '0;
      wd_cnt <= '0;
      out_valid <= 1'b0;
      out_product <= '0;
      err_timeout <= 1'b0;
`ifdef MUL_ISSUE_TAG_EN
      op_tag <= '0;
      out_tag <= '0;
`endif
    end else begin
      state <= state_nx;
`ifdef MUL_ISSUE_TAG_EN
      if (pop) {op_tag, mul_a, mul_b} <= fifo_dout;
      if (load) out_tag <= op_tag;
`else
      if (pop) {mul_a, mul_b} <= fifo_dout;
`endif
      wd_cnt <= (state == WAIT && !mul_done) ? wd_cnt + 1'b1 : '0;
      out_valid <= load | (out_valid & ~out_ready);
      if (load) out_product <= mul_product;
      err_timeout <= err_timeout | timeout;
    end
  assign mul_start = state == START;
  // held low throughout reset so the core is cleared too, released in the first IDLE cycle
  assign mul_rst_n = ~rst & (state != CLEAR);
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: randomized and directed checks of mul_issue_ctrl against a transaction-level model
module tb_mul_issue_ctrl;
  localparam int WIDTH = 8, SUB = 4, DEPTH = 4;
  localparam int N = (WIDTH / SUB) * (WIDTH / SUB);
  typedef struct packed {logic [7:0] a; logic [7:0] b; logic [3:0] tag;} op_t;
  logic clk = 0, rst = 1;
  logic in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, mul_start, mul_rst_n, mul_done, err_timeout;
  logic [7:0] in_a = 0, in_b = 0, mul_a, mul_b;
  logic [3:0] in_tag = 0;
  logic [15:0] out_product, mul_product;
`ifdef MUL_ISSUE_TAG_EN
  logic [3:0] out_tag;
`endif
  int checks = 0, errors = 0;
  bit core_dead = 0;
  int core_cnt = 0;
  logic [15:0] core_p = 0;
  logic core_d = 0;
  assign mul_product = core_p;
  assign mul_done = core_d;
  always #5 clk = ~clk;
  mul_issue_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
`ifdef MUL_ISSUE_TAG_EN
    .in_tag(in_tag), .out_tag(out_tag),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_rst_n(mul_rst_n),
    .mul_product(mul_product), .mul_done(mul_done), .err_timeout(err_timeout)
  );
  // core stand-in: accumulates a*b into product N cycles after start, never self-clears
  always @(posedge clk)
    if (!mul_rst_n) begin
      core_p <= 0;
      core_d <= 0;
      core_cnt <= 0;
    end else if (mul_start) begin
      core_d <= 0;
      core_cnt <= N - 1;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1 && !core_dead) begin
        core_p <= core_p + 16'(mul_a) * 16'(mul_b);
        core_d <= 1;
      end
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // transaction model: FIFO queue, one op in flight by phase, one output slot
  op_t mq[$];
  op_t mcur = '0;
  bit mbusy = 0, mov = 0, merr = 0;
  int mph = 0, mwd = 0;
  logic [15:0] mprod = 0;
  logic [3:0] mtag = 0;
  always @(negedge clk)
    if (rst) begin
      mq.delete();
      mcur = '0;
      mbusy = 0;
      mov = 0;
      merr = 0;
      mprod = 0;
      mtag = 0;
    end else begin
      bit drain, push, load;
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("out_valid", out_valid, mov);
      if (mov) chk("out_product", out_product, mprod);
`ifdef MUL_ISSUE_TAG_EN
      if (mov) chk("out_tag", out_tag, mtag);
`endif
      chk("mul_start", mul_start, mbusy && mph == 2);
      chk("mul_rst_n", mul_rst_n, !(mbusy && mph == 1));
      chk("err_timeout", err_timeout, merr);
      chk("mul_ab", {mul_a, mul_b}, {mcur.a, mcur.b});
      drain = mov && out_ready;
      push = in_valid && mq.size() < DEPTH;
      load = 0;
      if (!mbusy) begin
        if (mq.size() > 0) begin
          mcur = mq.pop_front();
          mbusy = 1;
          mph = 1;
        end
      end else if (mph == 1) mph = 2;
      else if (mph == 2) begin
        mph = 3;
        mwd = 0;
      end else if (mul_done) begin
        if (!mov || out_ready) begin
          load = 1;
          mbusy = 0;
        end
      end else if (mwd == N + 1) begin
        merr = 1;
        mbusy = 0;
      end else mwd++;
      if (load) begin
        mprod = 16'(mcur.a) * 16'(mcur.b);
        mtag = mcur.tag;
      end
      mov = load ? 1 : (drain ? 0 : mov);
      if (push) mq.push_back({in_a, in_b, in_tag});
    end
  task automatic push_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tg);
    int n = 0;
    in_valid = 1;
    in_a = a;
    in_b = b;
    in_tag = tg;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready stuck at 0 for %0d cycles", n);
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int ov_at, low_at, nlow, err_at, nout, nstart, ncap;
    logic [15:0] p1, cap_p[8];
    logic [3:0] t1, cap_tag[8];
    int cap_t[8];
    logic [15:0] bp_exp[6];
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_product", out_product, 0);
    chk("rst_mul_ab", {mul_a, mul_b}, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_mul_rst_n", mul_rst_n, 0);
    chk("rst_err", err_timeout, 0);
`ifdef MUL_ISSUE_TAG_EN
    chk("rst_out_tag", out_tag, 0);
`endif
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;
    // single op: handshake at k=0
    ov_at = -1; low_at = -1; nlow = 0; p1 = 0; t1 = 0;
    in_valid = 1; in_a = 8'h12; in_b = 8'h34; in_tag = 4'hA;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 0) chk("t1_accept", in_ready, 1);
      if (!mul_rst_n) begin nlow++; low_at = k; end
`ifdef MUL_ISSUE_TAG_EN
      if (out_valid && ov_at < 0) t1 = out_tag;
`endif
      if (out_valid && ov_at < 0) begin ov_at = k; p1 = out_product; end
      @(posedge clk);
      #1 in_valid = 0;
    end
    chk("t1_latency", ov_at, 8);
    chk("t1_product", p1, 16'h03A8);
    chk("t1_rstn_low_at", low_at, 2);
    chk("t1_rstn_low_count", nlow, 1);
`ifdef MUL_ISSUE_TAG_EN
    chk("t1_tag", t1, 4'hA);
`endif
    // back-to-back with out_ready=1
    ncap = 0;
    for (int k = 0; k < 26; k++) begin
      if (k == 0) begin in_valid = 1; in_a = 8'hFF; in_b = 8'hFF; in_tag = 4'h5; end
      else if (k == 1) begin in_a = 8'h03; in_b = 8'h05; in_tag = 4'h3; end
      else in_valid = 0;
      @(negedge clk);
      if (out_valid && ncap < 2) begin
        cap_p[ncap] = out_product;
        cap_t[ncap] = k;
`ifdef MUL_ISSUE_TAG_EN
        cap_tag[ncap] = out_tag;
`else
        cap_tag[ncap] = 0;
`endif
        ncap++;
      end
      @(posedge clk);
      #1;
    end
    chk("b2b_count", ncap, 2);
    chk("b2b_first_at", cap_t[0], 8);
    chk("b2b_first", cap_p[0], 16'hFE01);
    chk("b2b_second_at", cap_t[1], 15);
    chk("b2b_second", cap_p[1], 16'h000F);
`ifdef MUL_ISSUE_TAG_EN
    chk("b2b_tag", cap_tag[0], 4'h5);
`endif
    // backpressure
    out_ready = 0;
    push_op(8'h12, 8'h34, 4'h1);
    push_op(8'hFF, 8'hFF, 4'h2);
    push_op(8'h03, 8'h05, 4'h3);
    push_op(8'h07, 8'h09, 4'h4);
    repeat (20) @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_held_valid", out_valid, 1);
    chk("bp_held_product", out_product, 16'h03A8);
    chk("bp_stall_op", {mul_a, mul_b}, 16'hFFFF);
    chk("bp_stall_done", mul_done, 1);
    repeat (5) @(negedge clk);
    chk("bp_held_stable", out_product, 16'h03A8);
    @(posedge clk);
    #1;
    push_op(8'h11, 8'h22, 4'h5);
    push_op(8'h0A, 8'h0B, 4'h6);
    @(negedge clk);
    chk("bp_full_in_ready", in_ready, 0);
    @(posedge clk);
    #1 out_ready = 1;
    bp_exp = '{16'h03A8, 16'hFE01, 16'h000F, 16'h003F, 16'h0242, 16'h006E};
    ncap = 0;
    for (int k = 0; k < 120 && ncap < 6; k++) begin
      @(negedge clk);
      if (out_valid) begin
        chk($sformatf("bp_drain%0d", ncap), out_product, bp_exp[ncap]);
        ncap++;
      end
    end
    chk("bp_drain_count", ncap, 6);
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    // watchdog: core never raises done
    core_dead = 1;
    err_at = -1; nout = 0;
    in_valid = 1; in_a = 8'h12; in_b = 8'h34;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (err_timeout && err_at < 0) err_at = k;
      if (out_valid) nout++;
      @(posedge clk);
      #1 in_valid = 0;
    end
    chk("wd_err_at", err_at, 10);
    chk("wd_no_output", nout, 0);
    core_dead = 0;
    push_op(8'h03, 8'h05, 4'h7);
    ncap = 0;
    for (int k = 0; k < 30 && ncap == 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("wd_next_product", out_product, 16'h000F);
        ncap++;
      end
    end
    chk("wd_next_seen", ncap, 1);
    chk("wd_err_sticky", err_timeout, 1);
    @(posedge clk);
    #1;
    // reset mid-WAIT with a held result and a queued op
    out_ready = 0;
    push_op(8'h12, 8'h34, 4'h1);
    push_op(8'hFF, 8'hFF, 4'h2);
    push_op(8'h03, 8'h05, 4'h3);
    repeat (12) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_mul_rst_n", mul_rst_n, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_err", err_timeout, 0);
    @(posedge clk);
    #1 rst = 0;
    out_ready = 1;
    nout = 0; nstart = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) nout++;
      if (mul_start) nstart++;
    end
    chk("mrst_no_output", nout, 0);
    chk("mrst_fifo_empty", nstart, 0);
    @(posedge clk);
    #1;
    // randomized traffic, checked every cycle by the model
    for (int k = 0; k < 1500; k++) begin
      in_valid = $urandom_range(0, 2) != 0;
      in_a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      in_b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      in_tag = 4'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    out_ready = 1;
    repeat (60) @(posedge clk);
    #1;
    @(negedge clk);
    chk("final_out_valid", out_valid, 0);
    chk("final_in_ready", in_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
